// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, instruction-register
// handshake and redirect inputs. master = fetch unit, slave = its environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ir_ready;
  logic        ir_wr;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, ir_wr, inst, inst_pc,
    input  imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir_wr, inst, inst_pc,
    output imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding a DEPTH-entry prefetch queue.
// Optional macro FETCH_STATS_EN adds saturating fetch_cnt/flush_cnt outputs.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | one request outstanding, its response will be queued
// DROP  | one request outstanding, its response will be discarded
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]  fetch_cnt,
  output logic [15:0]  flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [PW:0]   count, count_after;
  logic [PW-1:0] head, tail;
  logic [31:0]   pc, req_pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic          push, pop, room, issue;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = WAIT;
      WAIT: begin
        if (bus.imem_rvalid)  state_nxt = issue ? WAIT : IDLE;
        else if (bus.redirect) state_nxt = DROP;
      end
      DROP: if (bus.imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // room looks at the occupancy after this cycle's push/pop so a request never overfills
  always_comb begin
    pop         = rst_n && (count != '0) && bus.ir_ready && !bus.redirect;
    push        = rst_n && (state == WAIT) && bus.imem_rvalid && !bus.redirect;
    count_after = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    room        = count_after < DEPTH_C;
    issue       = rst_n && !bus.redirect && room &&
                  ((state == IDLE) || ((state == WAIT) && bus.imem_rvalid));
    bus.ir_wr     = pop;
    bus.imem_req  = issue;
    bus.imem_addr = issue ? pc : '0;
  end

  assign bus.inst    = q_inst[head];
  assign bus.inst_pc = q_pc[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (bus.redirect) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      pc    <= bus.redirect_pc & ~32'h3;
    end else begin
      count <= count_after;
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= req_pc;
      q_inst[tail] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop && (fetch_cnt != 16'hFFFF))          fetch_cnt <= fetch_cnt + 16'd1;
      if (bus.redirect && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: queue-based reference model with a latency-programmable
// instruction memory, checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  mreq_t       mem_q[$];
  logic [31:0] exp_pc;
  int          outst, epoch, cyc, mem_lat;
  int          exp_fcnt, exp_flcnt;
  logic        nxt_rv;
  logic [31:0] nxt_addr, rsp_addr;
  int          nxt_ep, rsp_ep;

  // observation logs for the directed checks
  logic [31:0] req_log[$];
  logic [31:0] wr_log[$];
  int          wr_cyc[$];
  logic        last_rv, last_wr, last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] at(logic [31:0] q[$], int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic void clear_logs();
    req_log.delete();
    wr_log.delete();
    wr_cyc.delete();
  endfunction

  task automatic step();
    logic fresh, push, pop, room, exp_req;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_ir_wr", {31'd0, bus.ir_wr}, 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'd0);
      mq_pc.delete();
      mq_inst.delete();
      mem_q.delete();
      exp_pc    = RESET_PC;
      outst     = 0;
      epoch++;
      nxt_rv    = 1'b0;
      exp_fcnt  = 0;
      exp_flcnt = 0;
    end else begin
      fresh   = bus.imem_rvalid && (rsp_ep == epoch);
      push    = fresh && !bus.redirect;
      pop     = (mq_pc.size() != 0) && bus.ir_ready && !bus.redirect;
      room    = (int'(mq_pc.size()) + int'(push) - int'(pop)) < DEPTH;
      exp_req = !bus.redirect && room && ((outst == 0) || fresh);

      chk("ir_wr", {31'd0, bus.ir_wr}, {31'd0, pop});
      if (pop) begin
        chk("inst_pc", bus.inst_pc, mq_pc[0]);
        chk("inst", bus.inst, mq_inst[0]);
      end
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", bus.imem_addr, exp_pc);
`ifdef FETCH_STATS_EN
      chk("fetch_cnt", {16'd0, fetch_cnt}, 32'(exp_fcnt));
      chk("flush_cnt", {16'd0, flush_cnt}, 32'(exp_flcnt));
      if (pop && exp_fcnt < 65535) exp_fcnt++;
      if (bus.redirect && exp_flcnt < 65535) exp_flcnt++;
`endif

      last_rv   = bus.imem_rvalid;
      last_wr   = bus.ir_wr;
      last_req  = bus.imem_req;
      last_addr = bus.imem_addr;
      if (bus.ir_wr) begin
        wr_log.push_back(bus.inst_pc);
        wr_cyc.push_back(cyc);
      end
      if (bus.imem_req) req_log.push_back(bus.imem_addr);

      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (push) begin
        mq_pc.push_back(rsp_addr);
        mq_inst.push_back(memf(rsp_addr));
      end
      if (bus.redirect) begin
        mq_pc.delete();
        mq_inst.delete();
        exp_pc = bus.redirect_pc & ~32'h3;
        epoch++;
      end
      if (bus.imem_rvalid) outst--;
      if (bus.imem_req) begin
        outst++;
        mem_q.push_back('{addr: bus.imem_addr, due: cyc + mem_lat, ep: epoch});
        if (!bus.redirect) exp_pc = exp_pc + 32'd4;
      end
      nxt_rv = 1'b0;
      if (mem_q.size() != 0 && mem_q[0].due == cyc + 1) begin
        nxt_rv   = 1'b1;
        nxt_addr = mem_q[0].addr;
        nxt_ep   = mem_q[0].ep;
        void'(mem_q.pop_front());
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    bus.imem_rvalid = nxt_rv;
    bus.imem_rdata  = nxt_rv ? memf(nxt_addr) : 32'hBAD0_BAD0;
    rsp_addr        = nxt_addr;
    rsp_ep          = nxt_ep;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int rel;
    rst_n           = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.ir_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    epoch = 0; cyc = 0; mem_lat = 1; outst = 0;
    exp_pc = RESET_PC; exp_fcnt = 0; exp_flcnt = 0;
    nxt_rv = 1'b0; nxt_addr = '0; nxt_ep = 0; rsp_addr = '0; rsp_ep = -1;

    // streaming after reset: 2-cycle latency then one word per cycle
    do_reset();
    clear_logs();
    rel = cyc;
    steps(10);
    chk("t1_req0", at(req_log, 0), 32'h0);
    chk("t1_req1", at(req_log, 1), 32'h4);
    chk("t1_req2", at(req_log, 2), 32'h8);
    chk("t1_wr0", at(wr_log, 0), 32'h0);
    chk("t1_wr1", at(wr_log, 1), 32'h4);
    chk("t1_wr2", at(wr_log, 2), 32'h8);
    chk("t1_latency", 32'((wr_cyc.size() > 0) ? wr_cyc[0] - rel : -1), 32'd2);
    chk("t1_no_gap", 32'((wr_cyc.size() > 5) ? wr_cyc[5] - wr_cyc[0] : -1), 32'd5);

    // stalled consumer fills the queue with exactly DEPTH words
    bus.ir_ready = 1'b0;
    do_reset();
    clear_logs();
    steps(10);
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_req_idle", {31'd0, last_req}, 32'd0);
    bus.ir_ready = 1'b1;
    steps(6);
    chk("t2_wr0", at(wr_log, 0), 32'h0);
    chk("t2_wr3", at(wr_log, 3), 32'hC);
    chk("t2_resume", at(req_log, 4), 32'h10);

    // redirect while waiting; stale response arrives later and is dropped
    mem_lat = 4;
    do_reset();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    clear_logs();
    step();
    bus.redirect = 1'b0;
    steps(14);
    chk("t3_req_after", at(req_log, 0), 32'h100);
    chk("t3_first_wr", at(wr_log, 0), 32'h100);

    // pc wraps past the top of the address space
    mem_lat = 1;
    steps(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    clear_logs();
    step();
    bus.redirect = 1'b0;
    steps(6);
    chk("t4_req0", at(req_log, 0), 32'hFFFF_FFFC);
    chk("t4_req1", at(req_log, 1), 32'h0);
    chk("t4_wr1", at(wr_log, 1), 32'h0);

    // redirect coincident with a response and a ready consumer
    steps(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    step();
    bus.redirect = 1'b0;
    chk("t5_rvalid_present", {31'd0, last_rv}, 32'd1);
    chk("t5_wr_blocked", {31'd0, last_wr}, 32'd0);
    chk("t5_no_req", {31'd0, last_req}, 32'd0);
    step();
    chk("t5_empty", {31'd0, last_wr}, 32'd0);
    chk("t5_req", {31'd0, last_req}, 32'd1);
    chk("t5_req_addr", last_addr, 32'h0000_2000);

    // mixed traffic: varying latency, back-pressure and redirects
    for (int i = 0; i < 400; i++) begin
      mem_lat         = $urandom_range(1, 3);
      bus.ir_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom;
      step();
    end
    bus.redirect = 1'b0;
    bus.ir_ready = 1'b1;
    mem_lat      = 1;
    steps(8);

`ifdef FETCH_STATS_EN
    do_reset();
    steps(70000);
    chk("t6_fetch_sat", {16'd0, fetch_cnt}, 32'h0000_FFFF);
    rst_n = 1'b0;
    step();
    chk("t6_fetch_clr", {16'd0, fetch_cnt}, 32'h0);
    chk("t6_flush_clr", {16'd0, flush_cnt}, 32'h0);
    rst_n = 1'b1;
    steps(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
